// File: rtl/cpu_arb_pkg.sv
// Shared types and constants for the memory-port arbiter: FSM states,
// requester indices and the default watchdog limit.
package cpu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    XFER   = 2'd1,
    LOCKED = 2'd2
  } arb_state_e;

  localparam logic [1:0] REQ_IF  = 2'd0;
  localparam logic [1:0] REQ_MEM = 2'd1;
  localparam logic [1:0] REQ_DMA = 2'd2;
  localparam logic [1:0] REQ_DBG = 2'd3;

  localparam int DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/mem_port_arbiter_rr_pick4.sv
// Combinational round-robin pick over four requesters: the search starts at
// last+1 and wraps, so the previous owner is considered last.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic       any,
  output logic [1:0] win
);

  logic [1:0] cand [4];

  // cand[0] is the highest-priority index (last+1), cand[3] is last itself.
  for (genvar gi = 0; gi < 4; gi++) begin : g_cand
    assign cand[gi] = last + 2'(gi + 1);
  end

  always_comb begin
    any = 1'b0;
    win = last;
    for (int k = 3; k >= 0; k--) begin
      if (req[cand[k]]) begin
        any = 1'b1;
        win = cand[k];
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin owner of a single memory port shared by four requesters, with
// locked multi-beat ownership and a watchdog that aborts stalled transfers.
module mem_port_arbiter
  import cpu_arb_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int TO_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] lock,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic [3:0] ack,
  output logic       mem_valid,
  input  logic       mem_ready,
  output logic       timeout_err,
  output logic       busy
);

  arb_state_e      state_q, state_d;
  logic [3:0]      gnt_q, gnt_d;
  logic [1:0]      sel_q, sel_d;
  logic [3:0]      ack_q, ack_d;
  logic            mem_valid_q, mem_valid_d;
  logic            timeout_err_q, timeout_err_d;
  logic [1:0]      last_q, last_d;
  logic [TO_W-1:0] cnt_q, cnt_d;

  logic            pick_any;
  logic [1:0]      pick_win;

  rr_pick4 u_pick (
    .req  (req),
    .last (last_q),
    .any  (pick_any),
    .win  (pick_win)
  );

  localparam logic [TO_W-1:0] CNT_LIMIT = TO_W'(TIMEOUT - 1);

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    sel_d         = sel_q;
    ack_d         = 4'b0000;
    mem_valid_d   = mem_valid_q;
    timeout_err_d = 1'b0;
    last_d        = last_q;
    cnt_d         = cnt_q;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d     = XFER;
          gnt_d       = 4'b0001 << pick_win;
          sel_d       = pick_win;
          mem_valid_d = 1'b1;
          cnt_d       = '0;
        end
      end
      XFER: begin
        // mem_ready is checked first so completion beats the watchdog limit.
        if (mem_ready) begin
          ack_d       = gnt_q;
          mem_valid_d = 1'b0;
          if (lock[sel_q]) begin
            state_d = LOCKED;
          end else begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
            last_d  = sel_q;
          end
        end else if (cnt_q == CNT_LIMIT) begin
          timeout_err_d = 1'b1;
          state_d       = IDLE;
          gnt_d         = 4'b0000;
          mem_valid_d   = 1'b0;
          last_d        = sel_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LOCKED: begin
        if (req[sel_q]) begin
          state_d     = XFER;
          mem_valid_d = 1'b1;
          cnt_d       = '0;
        end else if (!lock[sel_q]) begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
          last_d  = sel_q;
        end
      end
      default: begin
        state_d     = IDLE;
        gnt_d       = 4'b0000;
        mem_valid_d = 1'b0;
      end
    endcase
  end

  // last resets to 3 so requester 0 is first in the search order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      gnt_q         <= 4'b0000;
      sel_q         <= 2'd0;
      ack_q         <= 4'b0000;
      mem_valid_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      last_q        <= 2'd3;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      sel_q         <= sel_d;
      ack_q         <= ack_d;
      mem_valid_q   <= mem_valid_d;
      timeout_err_q <= timeout_err_d;
      last_q        <= last_d;
      cnt_q         <= cnt_d;
    end
  end

  assign gnt         = gnt_q;
  assign sel         = sel_q;
  assign ack         = ack_q;
  assign mem_valid   = mem_valid_q;
  assign timeout_err = timeout_err_q;
  assign busy        = (state_q != IDLE);

endmodule
